glip_channel_downscale: RTL and testbench

GLIP_CHANNEL_DOWNSCALE -- requirements
Module: glip_channel_downscale

---
 rtl/glip_channel_downscale.sv | 80 ++++++++
 tb/tb_glip_channel_downscale.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/glip_channel_downscale.sv
// glip_channel width downscaler: splits each IN_WIDTH word accepted on the
// slave side into RATIO slices of OUT_WIDTH, emitted one per cycle on the
// master side. The last slice can overlap the acceptance of the next word,
// so a continuous stream runs with no bubbles.
module glip_channel_downscale #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CW    = $clog2(RATIO + 1);

  // Reject widths that do not divide evenly or that would not actually split.
  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
      $error("glip_channel_downscale: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
    end
  endgenerate

  typedef enum logic {EMPTY, SERIALIZE} state_e;

  logic [IN_WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  state_e              state;
  logic                in_hs, out_hs;

  // The slice count alone defines the state; there is no separate state register.
  assign state = (cnt_q == '0) ? EMPTY : SERIALIZE;

  // Ready when idle, or when the last slice leaves this very cycle. Reset
  // gating keeps the upstream from handing over a word that would be lost.
  assign in_ready  = ~rst & ((state == EMPTY) | ((cnt_q == CW'(1)) & out_ready));
  assign out_valid = (state == SERIALIZE);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  // Current slice is always at the "front" end of the word register.
  generate
    if (MSB_FIRST) begin : g_msb
      assign out_data = word_q[IN_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_lsb
      assign out_data = word_q[OUT_WIDTH-1:0];
    end
  endgenerate

  // Next state: a load wins over a shift (covers the overlapped last slice).
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (in_hs) begin
      word_d = in_data;
      cnt_d  = CW'(RATIO);
    end else if (out_hs) begin
      word_d = MSB_FIRST ? (word_q << OUT_WIDTH) : (word_q >> OUT_WIDTH);
      cnt_d  = cnt_q - CW'(1);
    end
  end

  // State registers; reset drops any partially serialized word at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_glip_channel_downscale.sv
// Directed bench for glip_channel_downscale: default 16->8 MSB-first, an
// LSB-first twin sharing its inputs, and a 32->8 instance with random
// backpressure. Inputs change on the falling edge, outputs checked 1ns later.
module tb_glip_channel_downscale;

  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] in_data = '0;
  logic        in_valid = 0;
  logic        out_ready = 0;
  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [7:0]  out_data_a, out_data_b;

  logic [31:0] in_data_c = '0;
  logic        in_valid_c = 0, out_ready_c = 0;
  logic        in_ready_c, out_valid_c;
  logic [7:0]  out_data_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  glip_channel_downscale #(.IN_WIDTH(16), .OUT_WIDTH(8), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready));

  glip_channel_downscale #(.IN_WIDTH(16), .OUT_WIDTH(8), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready));

  glip_channel_downscale #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst), .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive on the falling edge, settle, then let the caller check.
  task automatic cyc(input logic r, input logic [15:0] d, input logic v, input logic rdy);
    @(negedge clk);
    rst = r; in_data = d; in_valid = v; out_ready = rdy;
    #1;
  endtask

  // Expected A-side outputs for the back-to-back stream.
  logic [15:0] bb_din [6]  = '{16'h3344, 16'h3344, 16'h5566, 16'h5566, 16'h0000, 16'h0000};
  logic        bb_vin [6]  = '{1, 1, 1, 1, 0, 0};
  logic [7:0]  bb_exp [6]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic        bb_rdy [6]  = '{0, 1, 0, 1, 0, 1};

  initial begin
    logic [7:0] c_exp [4];
    int cnt_m, k;
    logic acc, rdy_exp;
    c_exp = '{8'h01, 8'h02, 8'h03, 8'h04};

    // Reset state
    #2;
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data",  out_data_a, 0);
    chk("rst_in_ready",  in_ready_a, 0);
    cyc(1, 16'h0, 0, 1);
    cyc(0, 16'h0, 0, 1);
    chk("post_rst_in_ready",  in_ready_a, 1);
    chk("post_rst_out_valid", out_valid_a, 0);

    // Single word, both slice orders
    cyc(0, 16'hA5C3, 1, 1);
    cyc(0, 16'hFFFF, 0, 1);
    chk("single_s0_a",   out_data_a, 8'hA5);
    chk("single_s0_b",   out_data_b, 8'hC3);
    chk("single_v0",     out_valid_a, 1);
    chk("single_rdy0",   in_ready_a, 0);
    cyc(0, 16'h0000, 0, 1);
    chk("single_s1_a",   out_data_a, 8'hC3);
    chk("single_s1_b",   out_data_b, 8'hA5);
    chk("single_rdy1",   in_ready_a, 1);
    cyc(0, 16'h0000, 0, 1);
    chk("single_done_v", out_valid_a, 0);
    chk("single_done_vb", out_valid_b, 0);

    // Back-to-back words, no bubbles
    cyc(0, 16'h1122, 1, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(0, bb_din[i], bb_vin[i], 1);
      chk($sformatf("b2b_data%0d", i), out_data_a, bb_exp[i]);
      chk($sformatf("b2b_valid%0d", i), out_valid_a, 1);
      chk($sformatf("b2b_rdy%0d", i), in_ready_a, bb_rdy[i]);
    end
    cyc(0, 16'h0, 0, 1);
    chk("b2b_end_valid", out_valid_a, 0);

    // Backpressure hold
    cyc(0, 16'hBEEF, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 16'h1234, 0, 0);
      chk($sformatf("hold_data%0d", i), out_data_a, 8'hBE);
      chk($sformatf("hold_valid%0d", i), out_valid_a, 1);
      chk($sformatf("hold_rdy%0d", i), in_ready_a, 0);
    end
    cyc(0, 16'h1234, 0, 1);
    chk("hold_rel_s0", out_data_a, 8'hBE);
    cyc(0, 16'h1234, 0, 1);
    chk("hold_rel_s1", out_data_a, 8'hEF);
    chk("hold_rel_v1", out_valid_a, 1);
    cyc(0, 16'h1234, 0, 1);
    chk("hold_end_v", out_valid_a, 0);

    // Reset mid-serialization
    cyc(0, 16'hDEAD, 1, 1);
    cyc(0, 16'h0, 0, 1);
    chk("mid_rst_s0", out_data_a, 8'hDE);
    cyc(1, 16'h0, 0, 1);
    chk("mid_rst_valid", out_valid_a, 0);
    chk("mid_rst_data",  out_data_a, 0);
    chk("mid_rst_rdy",   in_ready_a, 0);
    cyc(0, 16'h0102, 1, 1);
    chk("mid_rst_after_v",   out_valid_a, 0);
    chk("mid_rst_after_rdy", in_ready_a, 1);
    cyc(0, 16'h0, 0, 1);
    chk("mid_rst_n0", out_data_a, 8'h01);
    cyc(0, 16'h0, 0, 1);
    chk("mid_rst_n1", out_data_a, 8'h02);
    chk("mid_rst_n1v", out_valid_a, 1);
    cyc(0, 16'h0, 0, 1);
    chk("mid_rst_end", out_valid_a, 0);

    // 32->8 with random backpressure, checked against a slice-count model
    cnt_m = 0; k = 0; acc = 0;
    @(negedge clk);
    in_data_c = 32'h01020304; in_valid_c = 1;
    for (int i = 0; i < 80 && (k < 4 || cnt_m != 0); i++) begin
      if (i != 0) @(negedge clk);
      if (acc) in_valid_c = 0;
      out_ready_c = (i > 40) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      rdy_exp = (cnt_m == 0) || (cnt_m == 1 && out_ready_c);
      chk($sformatf("w32_rdy%0d", i), in_ready_c, rdy_exp);
      chk($sformatf("w32_vld%0d", i), out_valid_c, cnt_m != 0);
      if (cnt_m != 0 && out_ready_c) begin
        chk($sformatf("w32_slice%0d", k), out_data_c, c_exp[k]);
        k++;
      end
      if (in_valid_c && rdy_exp) begin
        cnt_m = 4; acc = 1;
      end else if (cnt_m != 0 && out_ready_c) begin
        cnt_m--;
      end
    end
    chk("w32_slice_count", k, 4);
    @(negedge clk);
    #1;
    chk("w32_end_valid", out_valid_c, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
